// File: rtl/frac_logic_cfg_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package frac_logic_cfg_loader_pkg;

  localparam int DEFAULT_CHAIN_LEN = 19;
  localparam int DEFAULT_WORD_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Host words needed to cover the whole chain; the last one may be partial.
  function automatic int word_count(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/frac_cfg_shifter.sv
// Serializer: word shift register, chain bit counter and optional readback
// capture (enabled by FRAC_CFG_READBACK_EN).
module frac_cfg_shifter
  import frac_logic_cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              tail,
  output logic              head,
  output logic              shift_en,
  output logic              word_end,
  output logic              chain_end,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WL_W  = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bits_left;
  logic [WL_W-1:0]   word_left;
  logic              active;

  // shreg is cleared at the end of every word, so its MSB is 0 whenever not shifting.
  assign head      = shreg[WORD_W-1];
  assign shift_en  = active;
  assign chain_end = active && (bits_left == CNT_W'(1));
  assign word_end  = active && ((word_left == WL_W'(1)) || (bits_left == CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bits_left <= '0;
      word_left <= '0;
      active    <= 1'b0;
    end else if (init) begin
      bits_left <= CNT_W'(CHAIN_LEN);
    end else if (load) begin
      shreg     <= word;
      word_left <= WL_W'(WORD_W);
      active    <= 1'b1;
    end else if (active) begin
      bits_left <= (bits_left != '0) ? bits_left - CNT_W'(1) : '0;
      word_left <= word_left - WL_W'(1);
      if (word_end) begin
        shreg  <= '0;
        active <= 1'b0;
      end else begin
        shreg  <= {shreg[WORD_W-2:0], 1'b0};
      end
    end
  end

`ifdef FRAC_CFG_READBACK_EN
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] cap;
  logic [WORD_W-1:0] cap_next;
  logic [IDX_W-1:0]  cap_idx;

  // word_left counts down from WORD_W, so tail bits land MSB first and a short word stays left-aligned.
  assign cap_idx = IDX_W'(word_left - WL_W'(1));

  always_comb begin
    cap_next          = cap;
    cap_next[cap_idx] = tail;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (load) begin
        cap <= '0;
      end else if (active) begin
        if (word_end) begin
          rb_data  <= cap_next;
          rb_valid <= 1'b1;
          cap      <= '0;
        end else begin
          cap      <= cap_next;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: rtl/frac_logic_cfg_loader.sv
// Loads a CHAIN_LEN-bit image from host words into a serial configuration
// chain. Optional readback of the old chain contents: FRAC_CFG_READBACK_EN.
module frac_logic_cfg_loader
  import frac_logic_cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  state_t state;
  logic   init;
  logic   load;
  logic   word_end;
  logic   chain_end;

  assign init = (state == IDLE) && start;
  assign load = cfg_ready && cfg_valid;

  frac_cfg_shifter #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_shifter (
    .clk       (prog_clk),
    .reset     (prog_reset),
    .init      (init),
    .load      (load),
    .word      (cfg_data),
    .tail      (ccff_tail),
    .head      (ccff_head),
    .shift_en  (ccff_shift_en),
    .word_end  (word_end),
    .chain_end (chain_end),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= IDLE;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= LOAD;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            state     <= SHIFT;
            cfg_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (word_end) begin
            if (chain_end) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= LOAD;
              cfg_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_logic_cfg_loader.sv
// Self-checking bench: queue-based reference model checked every cycle,
// directed literal scenarios, then randomized traffic.
module tb_frac_logic_cfg_loader;

  localparam int L = 19;
  localparam int W = 8;

  bit          clk = 1'b0;
  logic        prog_reset, start, cfg_valid, ccff_tail;
  logic [7:0]  cfg_data;
  logic        cfg_ready, ccff_head, ccff_shift_en, busy, done, rb_valid;
  logic [7:0]  rb_data;
  logic        start16, ready16, head16, sh16, busy16, done16, rbv16, tail16;
  logic [7:0]  rbd16;
  logic [L-1:0] chain;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frac_logic_cfg_loader dut (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .rb_data(rb_data), .rb_valid(rb_valid)
  );

  frac_logic_cfg_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start16), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(ready16), .ccff_head(head16),
    .ccff_shift_en(sh16), .ccff_tail(tail16), .busy(busy16), .done(done16),
    .rb_data(rbd16), .rb_valid(rbv16)
  );

  assign tail16    = 1'b0;
  assign ccff_tail = chain[L-1];

  // Behaves as the physical chain: shifts the head bit in whenever enabled.
  always @(posedge clk) begin
    if (ccff_shift_en === 1'b1) chain <= {chain[L-2:0], ccff_head};
  end

  // Reference model: phase 0 idle, 1 awaiting a word, 2 shifting, 3 done.
  int         m_phase = 0;
  int         m_bits  = 0;
  bit         m_init  = 1'b0;
  bit         m_q[$];
  bit         m_img[$];
  logic [7:0] m_cap;
  int         m_pos;
  logic       m_rbv = 1'b0;
  logic [7:0] m_rbd = 8'h00;

  always @(posedge clk) begin
    if (prog_reset) begin
      m_init = 1'b1; m_phase = 0; m_bits = 0; m_q.delete(); m_img.delete();
      m_rbv = 1'b0; m_rbd = 8'h00;
    end else if (m_init) begin
      m_rbv = 1'b0;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_bits = L; m_img.delete(); end
        1: if (cfg_valid) begin
             for (int i = 0; i < ((m_bits < W) ? m_bits : W); i++) begin
               m_q.push_back(cfg_data[W-1-i]);
               m_img.push_back(cfg_data[W-1-i]);
             end
             m_cap = 8'h00; m_pos = 0; m_phase = 2;
           end
        2: begin
             void'(m_q.pop_front());
             m_cap[W-1-m_pos] = ccff_tail;
             m_pos++; m_bits--;
             if (m_q.size() == 0) begin
               m_rbv = 1'b1; m_rbd = m_cap;
               m_phase = (m_bits == 0) ? 3 : 1;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  logic [13:0] got_v, exp_v;
  logic        exp_rbv;
  logic [7:0]  exp_rbd;
  bit          chain_ok;

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (m_init) begin
`ifdef FRAC_CFG_READBACK_EN
      exp_rbv = m_rbv; exp_rbd = m_rbd;
`else
      exp_rbv = 1'b0;  exp_rbd = 8'h00;
`endif
      got_v = {cfg_ready, ccff_shift_en, ccff_head, busy, done, rb_valid, rb_data};
      exp_v = {m_phase == 1, m_phase == 2, (m_phase == 2) ? m_q[0] : 1'b0,
               m_phase != 0, m_phase == 3, exp_rbv, exp_rbd};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%h expected=%h (ready,sh,head,busy,done,rbv,rbd)",
                 $time, got_v, exp_v);
      end
      if (m_phase == 3 && m_img.size() == L) begin
        chain_ok = 1'b1;
        for (int k = 0; k < L; k++) if (chain[k] !== m_img[L-1-k]) chain_ok = 1'b0;
        n_checks++;
        if (!chain_ok) begin
          n_fail++;
          $display("FAIL chain_image t=%0t got chain=%b", $time, chain);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic run_load(input bit use16, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap, input int rst_at, input bit extra,
                          output int done_cyc, output logic [18:0] heads, output int nshift,
                          output int ndone, output logic [23:0] rbw, output int nrb);
    logic [7:0] words [3];
    int  widx, gap_left, rst_cyc;
    bit  acc_prev, sh, rdy, dn;
    words[0] = w0; words[1] = w1; words[2] = w2;
    done_cyc = -1; heads = '0; nshift = 0; ndone = 0; rbw = '0; nrb = 0;
    widx = 0; acc_prev = 1'b0; gap_left = gap; rst_cyc = -10;
    @(negedge clk);
    cfg_data = w0; cfg_valid = 1'b1;
    if (use16) start16 = 1'b1; else start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0; start16 = 1'b0;
      sh  = use16 ? sh16 : ccff_shift_en;
      rdy = use16 ? ready16 : cfg_ready;
      dn  = use16 ? done16 : done;
      if (sh) begin heads = {heads[17:0], use16 ? head16 : ccff_head}; nshift++; end
      if (dn) begin ndone++; if (done_cyc < 0) done_cyc = c; if (extra) start = 1'b1; end
      if (!use16 && rb_valid) begin rbw = {rbw[15:0], rb_data}; nrb++; end
      if (c == rst_cyc + 1 || c == rst_cyc + 2)
        chk("reset_mid_shift_outputs", {26'd0, cfg_ready, ccff_shift_en, ccff_head, busy, done, rb_valid}, 32'd0);
      if (c == rst_cyc + 1) prog_reset = 1'b0;
      if (rst_at > 0 && rst_cyc < 0 && nshift == rst_at) begin prog_reset = 1'b1; rst_cyc = c; end
      if (extra && sh && nshift == 2) start = 1'b1;
      if (acc_prev) widx = (widx < 2) ? widx + 1 : 2;
      cfg_data = words[widx];
      if (widx == 1 && rdy && gap_left > 0) begin cfg_valid = 1'b0; gap_left--; end
      else cfg_valid = 1'b1;
      acc_prev = rdy && cfg_valid;
    end
    cfg_valid = 1'b0;
  endtask

  int          dcyc, nsh, ndn, nrb, rand_done;
  logic [18:0] hd;
  logic [23:0] rbw;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_reset = 1'b1; start = 1'b0; start16 = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    chain = L'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {18'd0, cfg_ready, ccff_shift_en, ccff_head, busy, done, rb_valid, rb_data}, 32'd0);
    chk("reset_outputs16", {26'd0, ready16, sh16, head16, busy16, done16, rbv16}, 32'd0);
    prog_reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {26'd0, cfg_ready, ccff_shift_en, ccff_head, busy, done, rb_valid}, 32'd0);

    // Back-to-back words.
    run_load(1'b0, 8'hA5, 8'h3C, 8'hE0, 0, 0, 1'b0, dcyc, hd, nsh, ndn, rbw, nrb);
    chk("basic_done_cycle", dcyc, 32'd23);
    chk("basic_head_seq", {13'd0, hd}, {13'd0, 19'b1010010100111100111});
    chk("basic_shift_count", nsh, 32'd19);
    chk("basic_done_pulses", ndn, 32'd1);

    // Host stalls for 5 cycles before the second word; chain now holds the previous image.
    run_load(1'b0, 8'hA5, 8'h3C, 8'hE0, 5, 0, 1'b0, dcyc, hd, nsh, ndn, rbw, nrb);
    chk("stall_done_cycle", dcyc, 32'd28);
    chk("stall_head_seq", {13'd0, hd}, {13'd0, 19'b1010010100111100111});
    chk("stall_shift_count", nsh, 32'd19);
`ifdef FRAC_CFG_READBACK_EN
    chk("readback_words", {8'd0, rbw}, {8'd0, 24'hA53CE0});
    chk("readback_pulses", nrb, 32'd3);
`else
    chk("readback_absent", nrb, 32'd0);
`endif

    // Reset during the 4th shift of the first word, then a clean reload.
    run_load(1'b0, 8'h5A, 8'hC3, 8'h20, 0, 4, 1'b0, dcyc, hd, nsh, ndn, rbw, nrb);
    chk("abort_no_done", ndn, 32'd0);
    chk("abort_shift_count", nsh, 32'd4);
    run_load(1'b0, 8'h5A, 8'hC3, 8'h20, 0, 0, 1'b0, dcyc, hd, nsh, ndn, rbw, nrb);
    chk("reload_done_cycle", dcyc, 32'd23);
    chk("reload_head_seq", {13'd0, hd}, {13'd0, 19'b0101101011000011001});

    // Stray starts during SHIFT and coincident with done.
    run_load(1'b0, 8'hFF, 8'h00, 8'hFF, 0, 0, 1'b1, dcyc, hd, nsh, ndn, rbw, nrb);
    chk("stray_start_done_pulses", ndn, 32'd1);
    chk("stray_start_shift_count", nsh, 32'd19);
    chk("stray_start_done_cycle", dcyc, 32'd23);

    // 16-bit chain: two full words, no partial word.
    run_load(1'b1, 8'h12, 8'h34, 8'h00, 0, 0, 1'b0, dcyc, hd, nsh, ndn, rbw, nrb);
    chk("len16_done_cycle", dcyc, 32'd19);
    chk("len16_head_seq", {13'd0, hd}, {13'd0, 19'h01234});
    chk("len16_shift_count", nsh, 32'd16);

    rand_done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) rand_done++;
      start      = ($urandom_range(0, 7) == 0);
      cfg_valid  = ($urandom_range(0, 9) < 7);
      cfg_data   = 8'($urandom);
      prog_reset = ($urandom_range(0, 299) == 0);
    end
    prog_reset = 1'b0; start = 1'b0; cfg_valid = 1'b1;
    repeat (60) @(negedge clk);
    chk("random_loads_completed", {31'd0, rand_done > 20}, 32'd1);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_logic_cfg_loader.md
FRAC_LOGIC_CFG_LOADER -- requirements
Module: frac_logic_cfg_loader

Interface
REQ-001 Parameter: CHAIN_LEN, default 19, number of configuration-chain flops served by this loader.
REQ-002 Parameter: WORD_W, default 8, width of one host configuration word.
REQ-003 Port: prog_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: prog_reset  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to load a full chain image.
REQ-006 Port: cfg_data  input  WORD_W  configuration word; the MSB is shifted first.
REQ-007 Port: cfg_valid  input  1  cfg_data is valid.
REQ-008 Port: cfg_ready  output  1  the loader accepts cfg_data this cycle.
REQ-009 Port: ccff_head  output  1  serial bit driven into the head of the configuration chain.
REQ-010 Port: ccff_shift_en  output  1  the chain shifts one position on this edge.
REQ-011 Port: ccff_tail  input  1  serial bit returned from the tail of the chain.
REQ-012 Port: busy  output  1  a load is in progress (any state other than IDLE).
REQ-013 Port: done  output  1  one-cycle pulse on load completion.
REQ-014 Port: rb_data  output  WORD_W  readback word (present only with the Configuration macro).
REQ-015 Port: rb_valid  output  1  one-cycle qualifier for rb_data.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE: if start=1, the FSM SHALL go to LOAD and set bits_left=CHAIN_LEN; start SHALL be ignored in every other state.
REQ-018 LOAD: cfg_ready SHALL be 1 only in this state; on cfg_valid&cfg_ready the word SHALL be latched into the shift register and the FSM SHALL go to SHIFT.
REQ-019 LOAD with cfg_valid=0: the FSM SHALL hold indefinitely; no timeout.
REQ-020 SHIFT: each cycle SHALL drive ccff_head=shreg[MSB] and ccff_shift_en=1, shift shreg left, and decrement bits_left.
REQ-021 SHIFT: the word SHALL end after min(WORD_W, bits_left) bits; the FSM SHALL then go to DONE if bits_left reaches 0, otherwise to LOAD.
REQ-022 Last partial word: only its upper CHAIN_LEN mod WORD_W bits SHALL be shifted; the lower bits SHALL be ignored.
REQ-023 Words consumed per load SHALL equal ceil(CHAIN_LEN/WORD_W): 3 for the defaults.
REQ-024 DONE: done=1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-025 ccff_shift_en SHALL be 0 outside SHIFT, and ccff_head SHALL be 0 outside SHIFT.
REQ-026 Latency with cfg_valid held at 1: done SHALL assert 1 + W + CHAIN_LEN cycles after the edge that samples start, where W is the number of words (23 cycles for the defaults).
REQ-027 A start coinciding with done SHALL be ignored, since the FSM is in DONE.
REQ-028 bits_left SHALL be wide enough for CHAIN_LEN and SHALL never wrap below 0.

Reset
REQ-029 prog_reset=1 at any edge SHALL force IDLE, bits_left=0, shreg=0 and rb_data=0.
REQ-030 While in reset and in the cycle after it, cfg_ready, ccff_shift_en, ccff_head, busy, done and rb_valid SHALL all be 0.
REQ-031 Reset mid-SHIFT SHALL abandon the load without a done pulse; the chain contents are then undefined and a new start is required.

Configuration
REQ-032 Macro FRAC_CFG_READBACK_EN: when defined, each SHIFT cycle SHALL sample ccff_tail into a readback register, MSB first.
REQ-033 With FRAC_CFG_READBACK_EN, rb_valid SHALL pulse for one cycle after each word's final shift, and rb_data SHALL hold the bits captured for that word (LSBs zero-padded for a partial word).
REQ-034 Without FRAC_CFG_READBACK_EN, rb_data SHALL be tied to 0, rb_valid to 0, and ccff_tail SHALL be unused.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (IDLE/LOAD/SHIFT/DONE), the default CHAIN_LEN/WORD_W constants, and a function computing the word count.
REQ-036 The serializer SHALL be one sub-module, frac_cfg_shifter, containing the shift register, the bit counter and the readback capture; the FSM SHALL stay in the top module.

Verification
REQ-037 Reset, then start with cfg_valid held at 1 and words 0xA5, 0x3C, 0xE0 -> 19 shift-enable cycles; head sequence is 10100101 00111100 111; done at cycle 23.
REQ-038 Same load with cfg_valid low for 5 cycles before word 2 -> the FSM holds in LOAD with no shifts; done at cycle 28.
REQ-039 prog_reset at the 4th SHIFT cycle of word 1 -> all outputs 0 next cycle; no done pulse; a later start performs a clean 23-cycle load.
REQ-040 start pulsed during SHIFT and again coincident with done -> both ignored; exactly one load and one done pulse.
REQ-041 FRAC_CFG_READBACK_EN defined, chain preloaded with a 19-bit image, new image shifted -> rb_data values match the old image MSB-first (last word padded, e.g. 0xE0 for 111), with 3 rb_valid pulses.
REQ-042 CHAIN_LEN=16 -> 2 words, no partial word; done at cycle 19.
